warp_bundle_queue: RTL and testbench

- Decoded-bundle buffer between decode and issue; it is the transmitter side of the issue stage's bundle ready/valid input.
- Accepts 0–2 bundles per cycle from decode into a circular buffer.
- Presents the oldest two bundles to issue as bundle0/bundle1, with per-slot valid.
- Issue consumes all presented valid bundles on handshake; i_flush discards contents on redirect.

---
 rtl/warp_bundle_queue.sv | 145 ++++++++++++++
 tb/tb_warp_bundle_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_bundle_queue.sv
// warp_bundle_queue: decoded-bundle circular buffer between decode and issue, 0-2 bundles in and out per cycle.
// Latency: a bundle enqueued in cycle t is presented in cycle t+1 (0 cycles when empty with bypass built in).
// Backpressure: o_in_ready comes from registered occupancy only (room for a full pair); an issue handshake pops every presented bundle.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset (clears pointers and count, not storage)
//   i_flush                 drop all queued bundles; overrides enqueue and dequeue in the same cycle
//   o_in_ready              queue can take two bundles this cycle
//   i_in0_valid/_bundle     older incoming bundle
//   i_in1_valid/_bundle     younger incoming bundle, only meaningful together with i_in0_valid
//   o_output_valid          o_bundle0 valid (issue input valid)
//   o_bundle1_valid         o_bundle1 valid
//   i_output_ready          issue accepts all presented bundles
//   o_bundle0/o_bundle1     oldest / second-oldest bundle, zero when not valid
//
// Optional feature: define WARP_BUNDLEQ_BYPASS_EN to let incoming bundles reach the
// outputs in the same cycle while the queue is empty; without it outputs come from storage only.

`ifndef BUNDLE_SIZE
`define BUNDLE_SIZE 32
`endif

module warp_bundle_queue #(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_flush,
   output logic                    o_in_ready,
   input  logic                    i_in0_valid,
   input  logic                    i_in1_valid,
   input  logic [`BUNDLE_SIZE-1:0] i_in0_bundle,
   input  logic [`BUNDLE_SIZE-1:0] i_in1_bundle,
   output logic                    o_output_valid,
   output logic                    o_bundle1_valid,
   input  logic                    i_output_ready,
   output logic [`BUNDLE_SIZE-1:0] o_bundle0,
   output logic [`BUNDLE_SIZE-1:0] o_bundle1
);

   localparam logic [PTR_W:0]   C_CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   C_CNT_TWO  = (PTR_W+1)'(2);
   localparam logic [PTR_W:0]   C_IN_LIMIT = (PTR_W+1)'(DEPTH-2);
   localparam logic [PTR_W-1:0] C_PTR_ONE  = (PTR_W)'(1);

   // Storage and pointer state
   logic [`BUNDLE_SIZE-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]        r_head;
   logic [PTR_W-1:0]        r_tail;
   logic [PTR_W:0]          r_count;

   // Combinational helpers
   logic [PTR_W-1:0]        w_head1;
   logic [PTR_W-1:0]        w_tail1;
   logic                    w_in_ready;
   logic                    w_q_vld0;
   logic                    w_q_vld1;
   logic [`BUNDLE_SIZE-1:0] w_q_dat0;
   logic [`BUNDLE_SIZE-1:0] w_q_dat1;
   logic                    w_bypass;
   logic                    w_bypass_take;
   logic                    w_wr_en;
   logic                    w_wr_pair;
   logic [PTR_W:0]          w_n_in;
   logic [PTR_W:0]          w_n_out;
   logic [PTR_W:0]          w_count_nxt;

   // DEPTH is a power of two, so pointer arithmetic wraps for free; a pair
   // straddling entry DEPTH-1/0 needs no special casing.
   assign w_head1 = r_head + C_PTR_ONE;
   assign w_tail1 = r_tail + C_PTR_ONE;

   // Room for a whole pair, from registered state only so decode never sees
   // a combinational path from issue's ready.
   assign w_in_ready = (r_count <= C_IN_LIMIT);
   assign o_in_ready = w_in_ready;

   assign w_q_vld0 = (r_count != '0);
   assign w_q_vld1 = (r_count >= C_CNT_TWO);
   assign w_q_dat0 = r_mem[r_head];
   assign w_q_dat1 = r_mem[w_head1];

`ifdef WARP_BUNDLEQ_BYPASS_EN
   // Empty queue: incoming bundles are shown directly; a flush cycle never bypasses.
   assign w_bypass = (r_count == '0) && !i_flush;
`else
   assign w_bypass = 1'b0;
`endif

   // Bypassed bundles taken by issue in the same cycle never touch storage.
   assign w_bypass_take = w_bypass & i_in0_valid & i_output_ready;

   // Valid while not ready is dropped; in1 alone is ignored.
   assign w_wr_en   = w_in_ready & i_in0_valid & ~w_bypass_take;
   assign w_wr_pair = w_wr_en & i_in1_valid;
   assign w_n_in    = w_wr_en ? (w_wr_pair ? C_CNT_TWO : C_CNT_ONE) : '0;

   // Dequeue uses stored valids only; during bypass count is 0 so this is 0.
   assign w_n_out = (w_q_vld0 & i_output_ready) ? (w_q_vld1 ? C_CNT_TWO : C_CNT_ONE) : '0;

   assign w_count_nxt = r_count + w_n_in - w_n_out;

   // Output mux; any slot without valid is forced to zero.
   always_comb begin
      o_output_valid  = w_q_vld0;
      o_bundle1_valid = w_q_vld1;
      o_bundle0       = w_q_vld0 ? w_q_dat0 : '0;
      o_bundle1       = w_q_vld1 ? w_q_dat1 : '0;
      if (w_bypass) begin
         o_output_valid  = i_in0_valid;
         o_bundle1_valid = i_in0_valid & i_in1_valid;
         o_bundle0       = i_in0_valid ? i_in0_bundle : '0;
         o_bundle1       = (i_in0_valid & i_in1_valid) ? i_in1_bundle : '0;
      end
   end

   // Pointers and occupancy. Reset beats flush; flush beats enqueue/dequeue.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + w_n_out[PTR_W-1:0];
         r_tail  <= r_tail + w_n_in[PTR_W-1:0];
         r_count <= w_count_nxt;
      end
   end

   // Storage is intentionally not reset; outputs are masked by the valids.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && !i_flush && w_wr_en) begin
         r_mem[r_tail] <= i_in0_bundle;
         if (w_wr_pair) begin
            r_mem[w_tail1] <= i_in1_bundle;
         end
      end
   end

endmodule

// File: tb/tb_warp_bundle_queue.sv
// tb_warp_bundle_queue: directed stimulus with a scoreboard for warp_bundle_queue.
// Expected bundles are queued as they are issued; a negedge monitor pops and compares on every handshake.
// Directed checks cover reset, ready thresholds, hold-while-stalled, flush and bypass latency.
`timescale 1ns/1ps
`ifndef BUNDLE_SIZE
`define BUNDLE_SIZE 32
`endif

module tb_warp_bundle_queue;
   localparam int BW = `BUNDLE_SIZE;
`ifdef WARP_BUNDLEQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_ready;
   logic          in0_v = 1'b0;
   logic          in1_v = 1'b0;
   logic [BW-1:0] in0_b = '0;
   logic [BW-1:0] in1_b = '0;
   logic          out_v;
   logic          b1_v;
   logic          out_rdy = 1'b0;
   logic [BW-1:0] b0;
   logic [BW-1:0] b1;

   int n_tests = 0;
   int n_fail  = 0;
   logic [BW-1:0] exp_q[$];

   always #5 clk = ~clk;

   warp_bundle_queue #(.DEPTH(8)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_flush        (flush),
      .o_in_ready     (in_ready),
      .i_in0_valid    (in0_v),
      .i_in1_valid    (in1_v),
      .i_in0_bundle   (in0_b),
      .i_in1_bundle   (in1_b),
      .o_output_valid (out_v),
      .o_bundle1_valid(b1_v),
      .i_output_ready (out_rdy),
      .o_bundle0      (b0),
      .o_bundle1      (b1)
   );

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: samples mid-cycle, pops one or two expected bundles per handshake.
   always @(negedge clk) begin
      if (rst_n && !flush) begin
         if (!out_v) chk("idle_b0_zero", b0, '0);
         if (!b1_v)  chk("idle_b1_zero", b1, '0);
         if (out_v && out_rdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", BW'(out_v), '0);
            end else begin
               automatic bit two = (exp_q.size() >= 2);
               chk("pop_b0", b0, exp_q[0]);
               chk("pop_b1_valid", BW'(b1_v), BW'(two));
               chk("pop_b1", b1, two ? exp_q[1] : '0);
               void'(exp_q.pop_front());
               if (two) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic drive(input logic v0, input logic v1, input logic [BW-1:0] d0,
                        input logic [BW-1:0] d1, input logic rdy);
      in0_v   = v0;
      in1_v   = v1;
      in0_b   = d0;
      in1_b   = d1;
      out_rdy = rdy;
   endtask

   task automatic drain();
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      chk("drain_done", BW'(exp_q.size()), '0);
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      settle();
      chk("drain_empty_valid", BW'(out_v), '0);
      tick();
   endtask

   initial begin
      // Reset with every input active
      rst_n = 1'b0;
      flush = 1'b1;
      drive(1'b1, 1'b1, 'hDEAD, 'hBEEF, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      flush = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      settle();
      chk("reset_out_valid", BW'(out_v), '0);
      chk("reset_b1_valid", BW'(b1_v), '0);
      chk("reset_b0", b0, '0);
      chk("reset_b1", b1, '0);
      chk("reset_in_ready", BW'(in_ready), BW'(1));
      tick();

      // Pair flow
      drive(1'b1, 1'b1, 'hA, 'hB, 1'b0);
      exp_q.push_back('hA);
      exp_q.push_back('hB);
      tick();
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      settle();
      chk("pair_out_valid", BW'(out_v), BW'(1));
      chk("pair_b1_valid", BW'(b1_v), BW'(1));
      chk("pair_b0", b0, 'hA);
      chk("pair_b1", b1, 'hB);
      tick();
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      settle();
      chk("pair_after_valid", BW'(out_v), '0);
      chk("pair_after_in_ready", BW'(in_ready), BW'(1));
      tick();

      // Backpressure to full with four pairs
      for (int p = 0; p < 4; p++) begin
         drive(1'b1, 1'b1, BW'('h10 + 2*p), BW'('h11 + 2*p), 1'b0);
         exp_q.push_back(BW'('h10 + 2*p));
         exp_q.push_back(BW'('h11 + 2*p));
         settle();
         chk("full_in_ready_before_pair", BW'(in_ready), BW'(1));
         if (p > 0) begin
            chk("full_hold_b0", b0, 'h10);
            chk("full_hold_b1", b1, 'h11);
         end
         tick();
      end
      drive(1'b1, 1'b1, 'hEE, 'hEF, 1'b0);
      settle();
      chk("full_in_ready", BW'(in_ready), '0);
      chk("full_out_valid", BW'(out_v), BW'(1));
      chk("full_hold_b0_extra", b0, 'h10);
      chk("full_hold_b1_extra", b1, 'h11);
      tick();
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      settle();
      chk("full_still_not_ready", BW'(in_ready), '0);
      chk("full_still_b0", b0, 'h10);
      tick();
      drain();

      // Odd count, then pairs straddling entry 7/0 on both write and read
      drive(1'b1, 1'b0, 'hC0, '0, 1'b0);
      exp_q.push_back('hC0);
      tick();
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      settle();
      chk("single_b1_valid", BW'(b1_v), '0);
      chk("single_b0", b0, 'hC0);
      tick();
      for (int p = 0; p < 4; p++) begin
         drive(1'b1, 1'b1, BW'('h20 + 2*p), BW'('h21 + 2*p), 1'b0);
         exp_q.push_back(BW'('h20 + 2*p));
         exp_q.push_back(BW'('h21 + 2*p));
         tick();
      end
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      settle();
      chk("wrap_full_in_ready", BW'(in_ready), '0);
      tick();
      drive(1'b1, 1'b0, 'h2F, '0, 1'b1);
      exp_q.push_back('h2F);
      settle();
      chk("wrap_in_ready", BW'(in_ready), BW'(1));
      tick();
      drain();

      // Simultaneous enqueue and dequeue at count 3
      drive(1'b1, 1'b1, 'h30, 'h31, 1'b0);
      exp_q.push_back('h30);
      exp_q.push_back('h31);
      tick();
      drive(1'b1, 1'b0, 'h32, '0, 1'b0);
      exp_q.push_back('h32);
      tick();
      drive(1'b1, 1'b1, 'h33, 'h34, 1'b1);
      exp_q.push_back('h33);
      exp_q.push_back('h34);
      settle();
      chk("sim_in_ready", BW'(in_ready), BW'(1));
      tick();
      drive(1'b1, 1'b1, 'h35, 'h36, 1'b0);
      exp_q.push_back('h35);
      exp_q.push_back('h36);
      settle();
      chk("sim_b0", b0, 'h32);
      chk("sim_b1", b1, 'h33);
      tick();
      drain();

      // Flush with concurrent enqueue and ready
      drive(1'b1, 1'b1, 'h40, 'h41, 1'b0);
      tick();
      flush = 1'b1;
      drive(1'b1, 1'b1, 'h42, 'h43, 1'b1);
      exp_q.delete();
      settle();
      chk("flush_cycle_out_valid", BW'(out_v), BW'(1));
      chk("flush_cycle_b0", b0, 'h40);
      tick();
      flush = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      settle();
      chk("post_flush_out_valid", BW'(out_v), '0);
      chk("post_flush_b1_valid", BW'(b1_v), '0);
      chk("post_flush_in_ready", BW'(in_ready), BW'(1));
      tick();
      drive(1'b1, 1'b0, 'h50, '0, 1'b0);
      exp_q.push_back('h50);
      tick();
      drain();

      // Bypass latency on an empty queue
      drive(1'b1, 1'b1, 'hD0, 'hE0, 1'b1);
      exp_q.push_back('hD0);
      exp_q.push_back('hE0);
      settle();
      chk("byp_same_out_valid", BW'(out_v), BW'(BYP));
      chk("byp_same_b0", b0, BYP ? BW'('hD0) : '0);
      chk("byp_same_b1", b1, BYP ? BW'('hE0) : '0);
      tick();
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      settle();
      chk("byp_next_out_valid", BW'(out_v), BW'(!BYP));
      tick();
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      settle();
      chk("byp_end_out_valid", BW'(out_v), '0);
      chk("scoreboard_empty", BW'(exp_q.size()), '0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
